// File: rtl/mpu_frame_assembler.sv
// ----------------------------------------------------------------------------
// mpu_frame_assembler
//
// Turns the byte stream of an MPU-6050 style burst read (ACCEL_XOUT_H ..
// GYRO_ZOUT_L, 14 bytes) into seven signed 16-bit words. Words are assembled
// big-endian into a staging bank. When byte 13 arrives, all seven outputs are
// published in the same edge. A one-cycle DONE state then follows, with
// frame_valid high. A byte that arrives in DONE is already byte 0 of the next
// frame, so back-to-back frames never lose a byte.
//
// A partial frame is discarded, with a one-cycle frame_err pulse, in two
// cases: frame_sync arrives mid-frame, or no byte arrives for GAP_CYCLES
// clocks. Reset discards a partial frame silently.
//
// Optional feature (macro MPU_FRAME_GYRO_OFFSET_EN): gyro bias correction.
// It subtracts gx_off/gy_off/gz_off from the raw gyro words at publish time,
// with the result saturated to 16-bit signed.
//
// Parameters
//   GAP_CYCLES   inter-byte timeout in clk cycles (2 .. 2^20-1)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   byte_in[7:0]          received sensor byte
//   byte_valid            one-cycle strobe qualifying byte_in
//   frame_sync            next accepted byte is frame byte 0
//   ax..gz[15:0]          signed words of the last complete frame
//   frame_valid           pulse: word outputs were updated this cycle
//   frame_err             pulse: a partial frame was discarded
//   byte_idx[3:0]         index of the next expected byte (0..13)
//   gx_off..gz_off[15:0]  gyro offsets (only with MPU_FRAME_GYRO_OFFSET_EN)
// ----------------------------------------------------------------------------
module mpu_frame_assembler #(
    parameter int GAP_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    input  logic               frame_sync,
    output logic signed [15:0] ax,
    output logic signed [15:0] ay,
    output logic signed [15:0] az,
    output logic signed [15:0] temp,
    output logic signed [15:0] gx,
    output logic signed [15:0] gy,
    output logic signed [15:0] gz,
    output logic               frame_valid,
    output logic               frame_err,
    output logic [3:0]         byte_idx
`ifdef MPU_FRAME_GYRO_OFFSET_EN
    ,
    input  logic signed [15:0] gx_off,
    input  logic signed [15:0] gy_off,
    input  logic signed [15:0] gz_off
`endif
);

    localparam int         FRAME_BYTES = 14;
    localparam int         WORDS       = FRAME_BYTES / 2;
    localparam logic [3:0] LAST_IDX    = 4'(FRAME_BYTES - 1);
    // The timer expires on the cycle in which it would reach GAP_CYCLES.
    localparam logic [19:0] GAP_LAST   = 20'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [3:0]         idx_next;
    logic [19:0]        timer, timer_next;

    logic               accept;     // byte_in is taken this cycle
    logic [3:0]         wr_idx;     // frame position of the accepted byte
    logic               publish;    // byte 13 accepted: load the outputs
    logic               err_pulse;  // partial frame discarded this cycle

    logic [7:0]         shadow;
    logic signed [15:0] staging [WORDS];

    logic signed [15:0] raw_gx, raw_gy, raw_gz;
    logic signed [15:0] gx_pub, gy_pub, gz_pub;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: registers are updated with non-blocking assignments, so every
    // always_ff block sees pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            byte_idx <= '0;
            timer    <= '0;
        end else begin
            state    <= state_next;
            byte_idx <= idx_next;
            timer    <= timer_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control
    // ------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        idx_next   = byte_idx;
        timer_next = timer;
        accept     = 1'b0;
        wr_idx     = '0;
        publish    = 1'b0;
        err_pulse  = 1'b0;

        unique case (state)
            // DONE behaves like IDLE for the incoming byte. Because it lasts
            // only one cycle, a byte strobed there starts the next frame.
            S_IDLE, S_DONE: begin
                state_next = S_IDLE;
                idx_next   = '0;
                timer_next = '0;
                if (byte_valid) begin
                    accept     = 1'b1;
                    idx_next   = 4'd1;
                    state_next = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (byte_valid) begin
                    // A byte beats both frame expiry and plain counting.
                    accept     = 1'b1;
                    timer_next = '0;
                    if (frame_sync) begin
                        // Restart: drop the partial frame, byte_in is byte 0.
                        err_pulse = 1'b1;
                        idx_next  = 4'd1;
                    end else if (byte_idx == LAST_IDX) begin
                        wr_idx     = byte_idx;
                        publish    = 1'b1;
                        idx_next   = '0;
                        state_next = S_DONE;
                    end else begin
                        wr_idx   = byte_idx;
                        idx_next = byte_idx + 4'd1;
                    end
                end else if (frame_sync || timer == GAP_LAST) begin
                    err_pulse  = 1'b1;
                    idx_next   = '0;
                    timer_next = '0;
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer + 20'd1;
                end
            end

            default: begin
                state_next = S_IDLE;
                idx_next   = '0;
                timer_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Publish values. Words 0..5 are already in staging. The last word is
    // still in flight ({shadow, byte_in}), so it bypasses staging. This lets
    // all seven outputs change on the same edge.
    // ------------------------------------------------------------------------
    assign raw_gx = staging[4];
    assign raw_gy = staging[5];
    assign raw_gz = {shadow, byte_in};

`ifdef MPU_FRAME_GYRO_OFFSET_EN
    // 17-bit difference of two 16-bit signed values. When the two top bits
    // disagree, the result has left the 16-bit range, and the sign bit tells
    // which rail to clamp to.
    function automatic logic signed [15:0] sat_sub(
        input logic signed [15:0] a,
        input logic signed [15:0] b
    );
        logic signed [16:0] d;
        d = {a[15], a} - {b[15], b};
        if (d[16] != d[15]) begin
            return d[16] ? 16'sh8000 : 16'sh7FFF;
        end
        return d[15:0];
    endfunction

    assign gx_pub = sat_sub(raw_gx, gx_off);
    assign gy_pub = sat_sub(raw_gy, gy_off);
    assign gz_pub = sat_sub(raw_gz, gz_off);
`else
    assign gx_pub = raw_gx;
    assign gy_pub = raw_gy;
    assign gz_pub = raw_gz;
`endif

    // ------------------------------------------------------------------------
    // Datapath: shadow/staging capture, output words and status pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            // NOTE: the staging bank is a handful of flops rather than a RAM,
            // so it takes the asynchronous reset like any other register.
            for (int i = 0; i < WORDS; i++) begin
                staging[i] <= '0;
            end
            ax          <= '0;
            ay          <= '0;
            az          <= '0;
            temp        <= '0;
            gx          <= '0;
            gy          <= '0;
            gz          <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= publish;
            frame_err   <= err_pulse;

            if (accept) begin
                if (!wr_idx[0]) begin
                    shadow <= byte_in;
                end else begin
                    staging[wr_idx[3:1]] <= {shadow, byte_in};
                end
            end

            if (publish) begin
                ax   <= staging[0];
                ay   <= staging[1];
                az   <= staging[2];
                temp <= staging[3];
                gx   <= gx_pub;
                gy   <= gy_pub;
                gz   <= gz_pub;
            end
        end
    end

endmodule

// File: doc/mpu_frame_assembler.md
MPU_FRAME_ASSEMBLER -- requirements
Module: mpu_frame_assembler

Interface
REQ-001 Parameter: GAP_CYCLES, default 50000, inter-byte timeout in clk cycles (1 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 Parameter: FRAME_BYTES, fixed at 14, bytes per sensor frame (ACCEL_XOUT_H..GYRO_ZOUT_L); it is not overridable.
REQ-003 clk  in  1  clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 byte_in  in  8  received sensor byte from the I2C reader.
REQ-006 byte_valid  in  1  one-cycle strobe; byte_in is valid in that cycle.
REQ-007 frame_sync  in  1  one-cycle pulse; the next accepted byte is frame byte 0.
REQ-008 ax, ay, az, temp, gx, gy, gz  out  16 each, signed  last complete frame words.
REQ-009 frame_valid  out  1  one-cycle pulse; the seven word outputs were updated this cycle.
REQ-010 frame_err  out  1  one-cycle pulse; a partial frame was discarded.
REQ-011 byte_idx  out  4  index of the next expected byte (0..13).

Function
REQ-012 State machine SHALL have three states: IDLE (no partial frame, byte_idx=0), COLLECT (1..13 bytes held) and DONE (one cycle; outputs publish).
REQ-013 Word assembly SHALL be big-endian.
- An even byte index is the high byte; it goes to a shadow register.
- The following odd byte is the low byte; {shadow, byte_in} is written to staging word (index>>1).
- Word order is ax, ay, az, temp, gx, gy, gz.
REQ-014 IDLE + byte_valid: accept as byte 0, byte_idx<=1, go to COLLECT.
REQ-015 COLLECT + byte_valid with byte_idx<13: accept, byte_idx<=byte_idx+1.
REQ-016 COLLECT + byte_valid with byte_idx=13: accept, byte_idx<=0, go to DONE.
REQ-017 DONE SHALL last exactly one cycle, with these effects:
- All seven outputs load from staging simultaneously.
- frame_valid=1.
- Next state is IDLE.
- Latency from the byte-13 capture edge to frame_valid high is 1 cycle.
REQ-018 byte_valid in the DONE cycle SHALL be accepted as byte 0 of the next frame (byte_idx<=1, next state COLLECT); no byte is ever dropped.
REQ-019 Word outputs SHALL hold their values between frame_valid pulses; staging writes SHALL never disturb the outputs.
REQ-020 frame_sync in COLLECT without byte_valid: discard the partial frame, frame_err=1 next cycle, go to IDLE.
REQ-021 frame_sync together with byte_valid in COLLECT: discard the partial frame, pulse frame_err, take byte_in as byte 0 (byte_idx<=1, stay in COLLECT).
REQ-022 frame_sync in IDLE or DONE SHALL be a no-op apart from the normal handling of any coincident byte_valid; frame_err stays 0.
REQ-023 Gap timer, 20-bit:
- Clears on every accepted byte.
- Counts every cycle in COLLECT.
- Reaching GAP_CYCLES: frame_err=1 next cycle, byte_idx<=0, go to IDLE.
- byte_valid in the same cycle as expiry wins: the byte is accepted and the timer clears.
REQ-024 frame_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-025 While rst_n is low, asynchronously, the block SHALL be in this state:
- State IDLE, byte_idx=0, timer=0.
- Shadow and staging registers =0.
- All word outputs =0.
- frame_valid=0, frame_err=0.
REQ-026 Reset mid-frame SHALL discard the partial frame without pulsing frame_err; the first byte after release is byte 0.

Configuration
REQ-027 With MPU_FRAME_GYRO_OFFSET_EN defined, gyro bias correction is compiled in:
- Added inputs gx_off, gy_off, gz_off (16-bit signed).
- At DONE, gx = sat16(raw_gx - gx_off); gy and gz likewise.
- Arithmetic is 17-bit signed, saturated to [-32768, 32767].
- ax, ay, az and temp are unaffected.
REQ-028 Without MPU_FRAME_GYRO_OFFSET_EN, the offset ports SHALL be absent and gyro outputs SHALL equal the raw words.

Verification
REQ-029 After reset, stream bytes 00..0D with one strobe every 3 cycles, then check:
- frame_valid pulses 1 cycle after byte 0D.
- ax=0x0001, ay=0x0203, az=0x0405, temp=0x0607, gx=0x0809, gy=0x0A0B, gz=0x0C0D.
REQ-030 Stream two back-to-back frames with byte_valid high continuously for 28 cycles, then check:
- Two frame_valid pulses, 14 cycles apart.
- Byte 0 of frame 2 is accepted during DONE.
- Both frames decode correctly.
REQ-031 Send 5 bytes, then idle GAP_CYCLES cycles (GAP_CYCLES=100), then check:
- frame_err pulses once, byte_idx=0.
- A following full frame decodes correctly.
- Outputs are unchanged before that frame.
REQ-032 Send 7 bytes, then frame_sync together with byte 0xAB, then 13 more bytes, then check:
- frame_err pulses once.
- ax[15:8]=0xAB.
- frame_valid follows the 13th byte.
REQ-033 Assert rst_n low after byte 9, then release and send a full frame; check all outputs=0 during reset, no frame_err, and the correct decode.
REQ-034 With MPU_FRAME_GYRO_OFFSET_EN, raw gx=0x8000, gx_off=0x0001 gives gx=0x8000 (saturated); raw gy=0x0100, gy_off=0xFF00 gives gy=0x0200.
